// File: rtl/comparator_sort_ctrl.sv
// Serial-in / serial-out block sorter: loads DEPTH 4-bit values, bubble-sorts them with one
// compare/swap per cycle, then streams them out ascending. Optional macro: SORT_EARLY_EXIT_EN.
module comparator_sort_ctrl #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH * (DEPTH - 1) / 2 + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] swap_cnt
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned D_W   = 4;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [D_W-1:0]   mem_q [DEPTH];
    logic [D_W-1:0]   mem_d [DEPTH];
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] pass_q, pass_d;
    logic [IDX_W-1:0] sort_idx_q, sort_idx_d;
    logic [CNT_W-1:0] swap_cnt_q, swap_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [D_W-1:0]   out_data_q, out_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SORT_EARLY_EXIT_EN
    logic             swapped_q, swapped_d;
`endif

    // Shared comparator: only its a>b result decides a swap, so equal keys keep their order.
    logic [IDX_W-1:0] sort_nxt_c;
    logic [D_W-1:0]   cmp_a_c;
    logic [D_W-1:0]   cmp_b_c;
    logic             cmp_x_c;
    logic             pass_end_c;
    logic             last_pass_c;

    assign sort_nxt_c = sort_idx_q + IDX_W'(1);
    assign cmp_a_c    = mem_q[sort_idx_q];
    assign cmp_b_c    = mem_q[sort_nxt_c];
    assign cmp_x_c    = (cmp_a_c > cmp_b_c);
    assign pass_end_c = (sort_idx_q == (IDX_W'(DEPTH - 2) - pass_q));

`ifdef SORT_EARLY_EXIT_EN
    // A pass that swapped nothing proves the block is already ordered.
    assign last_pass_c = (pass_q == IDX_W'(DEPTH - 2)) || (!swapped_q && !cmp_x_c);
`else
    assign last_pass_c = (pass_q == IDX_W'(DEPTH - 2));
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        pass_d     = pass_q;
        sort_idx_d = sort_idx_q;
        swap_cnt_d = swap_cnt_q;
        done_d     = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
        swapped_d  = swapped_q;
`endif

        case (state_q)
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_d    = ST_SORT;
                        wr_idx_d   = '0;
                        pass_d     = '0;
                        sort_idx_d = '0;
                        swap_cnt_d = '0;
`ifdef SORT_EARLY_EXIT_EN
                        swapped_d  = 1'b0;
`endif
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end

            ST_SORT: begin
                if (cmp_x_c) begin
                    mem_d[sort_idx_q] = cmp_b_c;
                    mem_d[sort_nxt_c] = cmp_a_c;
                    swap_cnt_d        = swap_cnt_q + CNT_W'(1);
`ifdef SORT_EARLY_EXIT_EN
                    swapped_d         = 1'b1;
`endif
                end
                if (pass_end_c) begin
                    if (last_pass_c) begin
                        state_d  = ST_OUT;
                        rd_idx_d = '0;
                    end else begin
                        pass_d     = pass_q + IDX_W'(1);
                        sort_idx_d = '0;
`ifdef SORT_EARLY_EXIT_EN
                        swapped_d  = 1'b0;
`endif
                    end
                end else begin
                    sort_idx_d = sort_nxt_c;
                end
            end

            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    if (rd_idx_q == IDX_W'(DEPTH - 1)) begin
                        done_d   = 1'b1;
                        rd_idx_d = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end

            default: state_d = ST_LOAD;
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_LOAD);
        out_data_d  = mem_d[rd_idx_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            pass_q      <= '0;
            sort_idx_q  <= '0;
            swap_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            pass_q      <= pass_d;
            sort_idx_q  <= sort_idx_d;
            swap_cnt_q  <= swap_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q   <= swapped_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign swap_cnt  = swap_cnt_q;

endmodule

// File: tb/tb_comparator_sort_ctrl.sv
// Self-checking bench for comparator_sort_ctrl: transaction-level sort model plus directed
// and randomized blocks.
module tb_comparator_sort_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] swap_cnt;

    comparator_sort_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .swap_cnt  (swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=loading, 1=sorting, 2=streaming out.
    bit m_init      = 1'b0;
    int m_phase     = 0;
    int m_buf[$];
    int m_sorted[DEPTH];
    int m_rd        = 0;
    int m_cnt       = 0;
    int m_left      = 0;
    int m_last_inv  = 0;
    bit m_done      = 1'b0;
    bit m_after_rst = 1'b0;
    int got[$];

    // Bubble sort swaps = inversion count; passes needed = largest count of larger elements before any element.
    function automatic int sort_cycles(input int p);
        int n;
        int passes;
        n = 0;
`ifdef SORT_EARLY_EXIT_EN
        passes = (p + 1 < DEPTH - 1) ? p + 1 : DEPTH - 1;
`else
        passes = DEPTH - 1;
`endif
        for (int k = 0; k < passes; k++) n += DEPTH - 1 - k;
        return n;
    endfunction

    task automatic model_sort();
        int a[DEPTH];
        int inv;
        int p;
        int c;
        int t;
        inv = 0;
        p   = 0;
        for (int k = 0; k < DEPTH; k++) a[k] = m_buf[k];
        for (int j = 0; j < DEPTH; j++) begin
            c = 0;
            for (int i = 0; i < j; i++) if (a[i] > a[j]) c++;
            inv += c;
            if (c > p) p = c;
        end
        for (int j = 1; j < DEPTH; j++) begin
            for (int i = j; i > 0 && a[i-1] > a[i]; i--) begin
                t = a[i]; a[i] = a[i-1]; a[i-1] = t;
            end
        end
        for (int k = 0; k < DEPTH; k++) m_sorted[k] = a[k];
        m_last_inv = inv;
        m_left     = sort_cycles(p);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            m_done      = 1'b0;
            m_after_rst = 1'b0;
            if (!rst_n) begin
                m_init      = 1'b1;
                m_phase     = 0;
                m_buf.delete();
                m_rd        = 0;
                m_cnt       = 0;
                m_after_rst = 1'b1;
            end else if (m_init) begin
                case (m_phase)
                    0: if (in_valid) begin
                        m_buf.push_back(int'(in_data));
                        if (m_buf.size() == DEPTH) begin
                            model_sort();
                            m_buf.delete();
                            m_phase = 1;
                        end
                    end
                    1: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = 2;
                            m_rd    = 0;
                            m_cnt   = m_last_inv;
                        end
                    end
                    default: if (out_ready) begin
                        got.push_back(int'(out_data));
                        if (m_rd == DEPTH - 1) begin
                            m_done  = 1'b1;
                            m_phase = 0;
                        end else begin
                            m_rd++;
                        end
                    end
                endcase
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("in_ready", int'(in_ready), int'(m_phase == 0));
                chk("busy", int'(busy), int'(m_phase != 0));
                chk("out_valid", int'(out_valid), int'(m_phase == 2));
                chk("done", int'(done), int'(m_done));
                if (m_phase == 2) chk("out_data", int'(out_data), m_sorted[m_rd]);
                if (m_phase != 1) chk("swap_cnt", int'(swap_cnt), m_cnt);
                if (m_after_rst) chk("out_data_after_reset", int'(out_data), 0);
            end
        end
    end

    function automatic logic [15:0] mk(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    task automatic load_block(input logic [15:0] blk, input int gap_pct);
        int   k;
        int   guard;
        logic rdy;
        k     = 0;
        guard = 0;
        rdy   = 1'b0;
        in_valid = 1'b0;
        while (k < DEPTH && guard < 300) begin
            @(negedge clk);
            guard++;
            if (in_valid && rdy) k++;
            if (k < DEPTH) begin
                rdy      = in_ready;
                in_valid = ($urandom_range(99) >= gap_pct);
                in_data  = in_valid ? blk[4*k +: 4] : 4'($urandom_range(15));
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("load_complete", k, DEPTH);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("wait_out_valid", int'(out_valid), 1);
    endtask

    // mode 0: always ready, 1: random ready, 2: alternate 1/0.
    task automatic drain(input int mode);
        int n;
        bit fin;
        n   = 0;
        fin = 1'b0;
        while (!fin && n < 300) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1));
                default: out_ready = (n % 2 == 0);
            endcase
            @(negedge clk);
            n++;
            if (done) begin
                fin = 1'b1;
                chk("in_ready_after_done", int'(in_ready), 1);
            end
        end
        out_ready = 1'b0;
        chk("drain_reached_done", int'(fin), 1);
    endtask

    task automatic check_got(input string name, input logic [15:0] exp);
        chk({name, "_count"}, got.size(), DEPTH);
        for (int k = 0; k < DEPTH && k < got.size(); k++)
            chk({name, "_elem"}, got[k], int'(exp[4*k +: 4]));
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int          lat;
        logic [15:0] blk;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_swap_cnt", int'(swap_cnt), 0);

        // 3,1,2,0 with in_valid held high
        got.delete();
        load_block(mk(3, 1, 2, 0), 0);
        chk("in_ready_low_after_load", int'(in_ready), 0);
        chk("model_inv_3120", m_last_inv, 5);
        wait_out(lat);
        chk("latency_3120", lat, 6);
        drain(0);
        check_got("blk_3120", mk(0, 1, 2, 3));
        chk("swap_cnt_3120", int'(swap_cnt), 5);

        // already sorted
        got.delete();
        load_block(mk(0, 1, 2, 3), 0);
        wait_out(lat);
`ifdef SORT_EARLY_EXIT_EN
        chk("latency_sorted", lat, 3);
`else
        chk("latency_sorted", lat, 6);
`endif
        drain(0);
        check_got("blk_0123", mk(0, 1, 2, 3));
        chk("swap_cnt_0123", int'(swap_cnt), 0);

        // duplicates stay stable
        got.delete();
        load_block(mk(15, 15, 7, 7), 0);
        drain(0);
        check_got("blk_dup", mk(7, 7, 15, 15));
        chk("swap_cnt_dup", int'(swap_cnt), 4);

        // output back-pressure
        got.delete();
        load_block(mk(9, 4, 12, 1), 0);
        wait_out(lat);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_out_data", int'(out_data), 1);
            chk("stall_out_valid", int'(out_valid), 1);
        end
        drain(2);
        check_got("blk_stall", mk(1, 4, 9, 12));
        chk("swap_cnt_stall", int'(swap_cnt), 4);

        // reset during SORT
        got.delete();
        load_block(mk(3, 2, 1, 0), 0);
        @(negedge clk);
        chk("busy_in_sort", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_swap_cnt", int'(swap_cnt), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_no_output", got.size(), 0);
        load_block(mk(2, 2, 0, 1), 0);
        drain(0);
        check_got("blk_after_abort", mk(0, 1, 2, 2));

        // back-to-back blocks
        got.delete();
        load_block(mk(15, 14, 13, 12), 0);
        drain(0);
        check_got("blk_b2b_a", mk(12, 13, 14, 15));
        chk("swap_cnt_b2b_a", int'(swap_cnt), 6);
        got.delete();
        load_block(mk(5, 6, 4, 7), 0);
        drain(0);
        check_got("blk_b2b_b", mk(4, 5, 6, 7));
        chk("swap_cnt_b2b_b", int'(swap_cnt), 2);

        // randomized blocks, gaps on input and random back-pressure on output
        for (int b = 0; b < 40; b++) begin
            got.delete();
            if (b % 3 == 0) begin
                for (int k = 0; k < DEPTH; k++) blk[4*k +: 4] = 4'($urandom_range(3));
            end else begin
                blk = 16'($urandom);
            end
            load_block(blk, 30);
            drain(1);
            chk("rand_count", got.size(), DEPTH);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
